// File: rtl/kbd_pkg.sv
// ============================================================================
// Module   : kbd_pkg
// Purpose  : Shared types and constants for the keyboard scancode controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package kbd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACK   = 2'd1,
        ST_PARSE = 2'd2
    } kbd_state_t;

    localparam logic [7:0] KBD_EXT = 8'hE0;
    localparam logic [7:0] KBD_BRK = 8'hF0;

    localparam int EV_BRK = 9;
    localparam int EV_EXT = 8;
    localparam int EV_W   = 10;

    function automatic logic [EV_W-1:0] make_event(input logic brk, input logic ext,
                                                   input logic [7:0] code);
        logic [EV_W-1:0] ev;
        ev         = '0;
        ev[EV_BRK] = brk;
        ev[EV_EXT] = ext;
        ev[7:0]    = code;
        return ev;
    endfunction

endpackage

`default_nettype wire

// File: rtl/kbd_ctrl_ev_fifo.sv
// ============================================================================
// Module   : ev_fifo
// Purpose  : Synchronous show-ahead FIFO holding decoded key events.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ev_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    localparam logic [AW:0] C_DEPTH = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign full  = (r_count == C_DEPTH);
    assign empty = (r_count == '0);
    assign count = r_count;
    assign dout  = empty ? '0 : r_mem[r_rd_ptr];

    // A pop frees a slot for a same-cycle push; an empty FIFO never pops the incoming word.
    assign w_do_pop  = pop & ~empty;
    assign w_do_push = push & (~full | w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/kbd_ctrl.sv
// ============================================================================
// Module   : kbd_ctrl
// Purpose  : PS/2 set-2 scancode sequencer folding E0/F0 prefixes into events.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module kbd_ctrl
    import kbd_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          clrn,
    input  logic          kbd_ready,
    input  logic [7:0]    kbd_data,
    output logic          kbd_read,
    input  logic          pop,
    output logic          ev_valid,
    output logic [9:0]    ev_data,
    output logic [AW:0]   ev_count,
    output logic          overflow,
    input  logic          clr_ovf
);

    kbd_state_t   r_state;
    logic         r_kbd_read;
    logic [7:0]   r_byte_q;
    logic         r_ext_f;
    logic         r_brk_f;
    logic         r_overflow;

    logic         w_is_prefix;
    logic         w_push;
    logic         w_full;
    logic         w_empty;
    logic         w_drop;
    logic [9:0]   w_event;

    assign w_is_prefix = (r_byte_q == KBD_EXT) || (r_byte_q == KBD_BRK);
    assign w_push      = (r_state == ST_PARSE) && !w_is_prefix;
    assign w_drop      = w_push & w_full & ~pop;
    assign w_event     = make_event(r_brk_f, r_ext_f, r_byte_q);

    assign kbd_read = r_kbd_read;
    assign ev_valid = ~w_empty;
    assign overflow = r_overflow;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_state    <= ST_IDLE;
            r_kbd_read <= 1'b0;
            r_byte_q   <= 8'h00;
            r_ext_f    <= 1'b0;
            r_brk_f    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (kbd_ready) begin
                        r_state    <= ST_ACK;
                        r_kbd_read <= 1'b1;
                    end
                end
                ST_ACK: begin
                    r_byte_q   <= kbd_data;
                    r_kbd_read <= 1'b0;
                    r_state    <= ST_PARSE;
                end
                ST_PARSE: begin
                    // Flags clear on every non-prefix byte, even when the event is dropped.
                    if (r_byte_q == KBD_EXT) begin
                        r_ext_f <= 1'b1;
                    end else if (r_byte_q == KBD_BRK) begin
                        r_brk_f <= 1'b1;
                    end else begin
                        r_ext_f <= 1'b0;
                        r_brk_f <= 1'b0;
                    end
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_kbd_read <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (clr_ovf) begin
            r_overflow <= 1'b0;
        end
    end

    ev_fifo #(
        .WIDTH (EV_W),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ev_fifo (
        .clk   (clk),
        .clrn  (clrn),
        .push  (w_push),
        .pop   (pop),
        .din   (w_event),
        .dout  (ev_data),
        .full  (w_full),
        .empty (w_empty),
        .count (ev_count)
    );

endmodule

`default_nettype wire

// File: tb/tb_kbd_ctrl.sv
// ============================================================================
// Module   : tb_kbd_ctrl
// Purpose  : Scoreboard bench for kbd_ctrl with a byte-queue PS/2 driver model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_kbd_ctrl;

    logic       clk       = 1'b0;
    logic       clrn      = 1'b0;
    logic       kbd_ready = 1'b0;
    logic [7:0] kbd_data  = 8'h00;
    logic       pop       = 1'b0;
    logic       clr_ovf   = 1'b0;
    logic       kbd_read;
    logic       ev_valid;
    logic [9:0] ev_data;
    logic [3:0] ev_count;
    logic       overflow;

    int         checks    = 0;
    int         errors    = 0;
    int         rd_pulses = 0;
    logic       prev_rd   = 1'b0;

    logic [7:0] drv_q [$];
    logic [9:0] exp_q [$];

    kbd_ctrl #(.DEPTH(8), .AW(3)) dut (
        .clk       (clk),
        .clrn      (clrn),
        .kbd_ready (kbd_ready),
        .kbd_data  (kbd_data),
        .kbd_read  (kbd_read),
        .pop       (pop),
        .ev_valid  (ev_valid),
        .ev_data   (ev_data),
        .ev_count  (ev_count),
        .overflow  (overflow),
        .clr_ovf   (clr_ovf)
    );

    always #5 clk = ~clk;

    // Driver model: head byte advances after an edge where kbd_read & kbd_ready.
    initial begin : driver
        logic ack;
        forever begin
            @(negedge clk);
            ack = kbd_read && kbd_ready;
            @(posedge clk);
            #1;
            if (ack && drv_q.size() > 0) void'(drv_q.pop_front());
            kbd_ready = (drv_q.size() != 0);
            kbd_data  = kbd_ready ? drv_q[0] : 8'h00;
        end
    end

    always @(negedge clk) begin
        if (kbd_read) begin
            rd_pulses++;
            checks++;
            if (prev_rd) begin
                errors++;
                $display("FAIL kbd_read_b2b: kbd_read high two cycles in a row, required single pulse");
            end
        end
        prev_rd = kbd_read;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic wait_drained(input int budget);
        int n = 0;
        while ((drv_q.size() != 0 || kbd_ready) && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (n >= budget) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: driver still holds %0d bytes, required 0", drv_q.size());
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_drain(input string tag);
        int n = 0;
        while (exp_q.size() > 0 && n < 20) begin
            @(negedge clk);
            n++;
            checks++;
            if (ev_valid !== 1'b1 || ev_data !== exp_q[0]) begin
                errors++;
                $display("FAIL %s_pop: valid=%0b data=%h, required valid=1 data=%h",
                         tag, ev_valid, ev_data, exp_q[0]);
            end
            void'(exp_q.pop_front());
            pop = 1'b1;
            @(posedge clk);
            #1 pop = 1'b0;
        end
        @(negedge clk);
        checks++;
        if (ev_valid !== 1'b0 || ev_data !== 10'h000 || ev_count !== 4'd0) begin
            errors++;
            $display("FAIL %s_empty: valid=%0b data=%h count=%0d, required 0/000/0",
                     tag, ev_valid, ev_data, ev_count);
        end
    endtask

    task automatic test_reset();
        clrn = 1'b0;
        #3;
        checks++;
        if ({kbd_read, ev_valid, ev_data, ev_count, overflow} !== 17'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h, required 0",
                     {kbd_read, ev_valid, ev_data, ev_count, overflow});
        end
        @(negedge clk);
        clrn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_make();
        int         base = rd_pulses;
        int         n    = 0;
        logic [2:0] seen;
        exp_q.push_back(10'h01C);
        drv_q.push_back(8'h1C);
        @(negedge clk);
        while (!kbd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            seen[k] = ev_valid;
        end
        checks++;
        if (seen !== 3'b100) begin
            errors++;
            $display("FAIL make_latency: valid history %b, required 100", seen);
        end
        checks++;
        if (ev_data !== 10'h01C || ev_count !== 4'd1) begin
            errors++;
            $display("FAIL make_head: data=%h count=%0d, required 01c/1", ev_data, ev_count);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (rd_pulses - base != 1) begin
            errors++;
            $display("FAIL make_reads: %0d kbd_read pulses, required 1", rd_pulses - base);
        end
        test_drain("make");
    endtask

    task automatic test_ext_break();
        int   base    = rd_pulses;
        int   n       = 0;
        logic bad_cnt = 1'b0;
        exp_q.push_back(10'h375);
        drv_q.push_back(8'hE0);
        drv_q.push_back(8'hF0);
        drv_q.push_back(8'h75);
        @(negedge clk);
        while (!ev_valid && n < 40) begin
            if (ev_count !== 4'd0) bad_cnt = 1'b1;
            @(negedge clk);
            n++;
        end
        checks++;
        if (!ev_valid || bad_cnt) begin
            errors++;
            $display("FAIL extbrk_wait: valid=%0b early_count=%0b, required 1/0", ev_valid, bad_cnt);
        end
        checks++;
        if (rd_pulses - base != 3) begin
            errors++;
            $display("FAIL extbrk_reads: %0d kbd_read pulses, required 3", rd_pulses - base);
        end
        test_drain("extbrk");
    endtask

    task automatic test_prefixes();
        logic [7:0] bytes [6] = '{8'hE0, 8'hE0, 8'h1C, 8'hF0, 8'hE1, 8'hAA};
        foreach (bytes[i]) drv_q.push_back(bytes[i]);
        exp_q.push_back(10'h11C);
        exp_q.push_back(10'h2E1);
        exp_q.push_back(10'h0AA);
        wait_drained(80);
        checks++;
        if (ev_count !== 4'd3) begin
            errors++;
            $display("FAIL prefix_count: count=%0d, required 3", ev_count);
        end
        test_drain("prefix");
    endtask

    task automatic test_fill_overflow();
        for (int i = 0; i < 10; i++) begin
            drv_q.push_back(8'h10 + 8'(i));
            if (i < 8) exp_q.push_back(10'h010 + 10'(i));
        end
        wait_drained(120);
        checks++;
        if (ev_count !== 4'd8 || overflow !== 1'b1 || ev_data !== 10'h010) begin
            errors++;
            $display("FAIL fill_state: count=%0d ovf=%0b head=%h, required 8/1/010",
                     ev_count, overflow, ev_data);
        end
        test_drain("fill");
        checks++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_sticky: overflow=%0b, required 1", overflow);
        end
        clr_ovf = 1'b1;
        @(posedge clk);
        #1 clr_ovf = 1'b0;
        @(negedge clk);
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear: overflow=%0b, required 0", overflow);
        end
    endtask

    task automatic test_push_pop_full();
        int n = 0;
        for (int i = 0; i < 8; i++) begin
            drv_q.push_back(8'h20 + 8'(i));
            exp_q.push_back(10'h020 + 10'(i));
        end
        wait_drained(100);
        drv_q.push_back(8'h28);
        exp_q.push_back(10'h028);
        @(negedge clk);
        while (!kbd_read && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (ev_data !== exp_q[0]) begin
            errors++;
            $display("FAIL ppfull_head: data=%h, required %h", ev_data, exp_q[0]);
        end
        void'(exp_q.pop_front());
        pop = 1'b1;
        @(posedge clk);
        #1 pop = 1'b0;
        @(negedge clk);
        checks++;
        if (ev_count !== 4'd8 || overflow !== 1'b0 || ev_data !== 10'h021) begin
            errors++;
            $display("FAIL ppfull_state: count=%0d ovf=%0b head=%h, required 8/0/021",
                     ev_count, overflow, ev_data);
        end
        test_drain("ppfull");
    endtask

    task automatic test_push_pop_empty();
        int n = 0;
        drv_q.push_back(8'h33);
        exp_q.push_back(10'h033);
        @(negedge clk);
        while (!kbd_read && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        @(negedge clk);
        pop = 1'b1;
        @(posedge clk);
        #1 pop = 1'b0;
        @(negedge clk);
        checks++;
        if (ev_count !== 4'd1 || ev_data !== 10'h033) begin
            errors++;
            $display("FAIL ppempty_state: count=%0d head=%h, required 1/033", ev_count, ev_data);
        end
        test_drain("ppempty");
    endtask

    task automatic test_reset_mid();
        drv_q.push_back(8'h44);
        drv_q.push_back(8'hF0);
        wait_drained(40);
        checks++;
        if (ev_count !== 4'd1) begin
            errors++;
            $display("FAIL rstmid_pre: count=%0d, required 1", ev_count);
        end
        @(negedge clk);
        clrn = 1'b0;
        #1;
        checks++;
        if ({kbd_read, ev_valid, ev_data, ev_count, overflow} !== 17'd0) begin
            errors++;
            $display("FAIL rstmid_outputs: got %h, required 0",
                     {kbd_read, ev_valid, ev_data, ev_count, overflow});
        end
        repeat (2) @(negedge clk);
        clrn = 1'b1;
        drv_q.push_back(8'h1C);
        exp_q.push_back(10'h01C);
        wait_drained(40);
        checks++;
        if (ev_count !== 4'd1) begin
            errors++;
            $display("FAIL rstmid_post: count=%0d, required 1", ev_count);
        end
        test_drain("rstmid");
    endtask

    task automatic test_idle();
        int   base = rd_pulses;
        logic bad  = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (ev_count !== 4'd0 || ev_valid !== 1'b0) bad = 1'b1;
            pop = k[0];
        end
        @(negedge clk);
        pop = 1'b0;
        checks++;
        if (bad || rd_pulses != base || ev_count !== 4'd0) begin
            errors++;
            $display("FAIL idle: reads=%0d bad=%0b count=%0d, required 0/0/0",
                     rd_pulses - base, bad, ev_count);
        end
    endtask

    initial begin
        test_reset();
        test_single_make();
        test_ext_break();
        test_prefixes();
        test_fill_overflow();
        test_push_pop_full();
        test_push_pop_empty();
        test_reset_mid();
        test_idle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
